// File: rtl/sram16_ctrl.sv
// sram16_ctrl: 32-bit single-outstanding request/response bus to a 256Kx16
// asynchronous SRAM (IS61LV25616). Each word access is split into a low
// half-word phase followed by a high half-word phase of WAIT_CYCLES+1 cycles
// each. Every SRAM pin and bus output comes straight from a flop.
//
// Optional feature: define SRAM16_CTRL_ALIGN_CHECK_EN to reject requests whose
// req_addr[1:0] != 0 with an immediate error response and no SRAM activity.
// Without it the two low address bits are ignored and rsp_err stays 0.
//
// WAIT_CYCLES must lie in 1..7 so the phase counter fits in three bits.

module sram16_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    // request channel
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [18:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byteen,
    // response channel
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    // SRAM pins
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_data,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Counter value of the final cycle of a phase (phase length WAIT_CYCLES+1).
    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

    // Sequencing state
    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    // Request captured at acceptance
    logic [16:0] waddr_q, waddr_d;
    logic        write_q, write_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;

    // Bus-side outputs
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // SRAM-side outputs
    logic [17:0] saddr_q, saddr_d;
    logic        ce_n_q, ce_n_d;
    logic        we_n_q, we_n_d;
    logic        oe_n_q, oe_n_d;
    logic        ub_n_q, ub_n_d;
    logic        lb_n_q, lb_n_d;
    logic        drv_q, drv_d;
    logic [15:0] dout_q, dout_d;

    logic        misalign;
    logic        in_phase;
    logic        phase_hi;

`ifdef SRAM16_CTRL_ALIGN_CHECK_EN
    assign misalign = (req_addr[1:0] != 2'b00);
`else
    // Byte offset within the word has no meaning for this bus without the check.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];
    assign misalign        = 1'b0;
`endif

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign sram_addr = saddr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_we_n = we_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_ub_n = ub_n_q;
    assign sram_lb_n = lb_n_q;
    assign sram_data = drv_q ? dout_q : 16'bz;

    // Next state: acceptance, phase counting, write-half skipping, read capture.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        write_d = write_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    waddr_d = req_addr[18:2];
                    write_d = req_write;
                    be_d    = req_byteen;
                    wdata_d = req_wdata;
                    cnt_d   = 3'd0;
                    if (misalign) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else if (!req_write || (|req_byteen[1:0])) begin
                        state_d = ST_LO;
                    end else if (|req_byteen[3:2]) begin
                        state_d = ST_HI;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_LO: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = 3'd0;
                    if (!write_q) begin
                        rdata_d[15:0] = sram_data;
                    end
                    state_d = (write_q && (be_q[3:2] == 2'b00)) ? ST_RESP : ST_HI;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_HI: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = 3'd0;
                    if (!write_q) begin
                        rdata_d[31:16] = sram_data;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_RESP);
    end

    // Pin values for the coming cycle, derived from the next state so the
    // strobes are already valid in the first cycle of each phase.
    always_comb begin
        in_phase = (state_d == ST_LO) || (state_d == ST_HI);
        phase_hi = (state_d == ST_HI);
        saddr_d  = saddr_q;
        ce_n_d   = 1'b1;
        we_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        ub_n_d   = 1'b1;
        lb_n_d   = 1'b1;
        drv_d    = 1'b0;
        dout_d   = dout_q;

        if (in_phase) begin
            saddr_d = {waddr_d, phase_hi};
            ce_n_d  = 1'b0;
            if (write_d) begin
                // WE_n released in the last cycle of the phase for data hold.
                we_n_d = (cnt_d == LAST_CNT);
                lb_n_d = phase_hi ? ~be_d[2] : ~be_d[0];
                ub_n_d = phase_hi ? ~be_d[3] : ~be_d[1];
                drv_d  = 1'b1;
                dout_d = phase_hi ? wdata_d[31:16] : wdata_d[15:0];
            end else begin
                oe_n_d = 1'b0;
                ub_n_d = 1'b0;
                lb_n_d = 1'b0;
            end
        end
    end

    // State and output registers; reset parks the SRAM and aborts any access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            waddr_q <= 17'd0;
            write_q <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            saddr_q <= 18'd0;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            drv_q   <= 1'b0;
            dout_q  <= 16'd0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            write_q <= write_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            saddr_q <= saddr_d;
            ce_n_q  <= ce_n_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            ub_n_q  <= ub_n_d;
            lb_n_q  <= lb_n_d;
            drv_q   <= drv_d;
            dout_q  <= dout_d;
        end
    end

endmodule
